button_debounce_arbiter: RTL
============================

// Module: button_debounce_arbiter
// PURPOSE
//   Shares one debounce hold-off timer between N_BTN active-low push-buttons.
//   Latches each press and grants the timer round-robin. After the hold-off, it
//   re-samples the granted button. A confirmed press drives a PULSE_CYC-long
//   LED pulse on that button's lane. Sits between board buttons and LED/UI logic.
// PARAMETERS
//   N_BTN      4         number of button requesters (2..16)
//   DELAY_W    25        hold-off counter width
//   DELAY_CNT  16777216  hold-off length in clk cycles (1..2^DELAY_W-1)
//   PULSE_CYC  1         LED pulse length in clk cycles (>=1)
//   IDX_W      $clog2(N_BTN)  index width (derived, not overridden)
// PORTS
//   clk       in   1       system clock, all state on rising edge
//   rst       in   1       asynchronous reset, active-low
//   button    in   N_BTN   raw buttons, active-low (pressed = 0), asynchronous
//   LED       out  N_BTN   one-hot confirmed-press pulse; 0 when idle
//   busy      out  1       1 while state != IDLE
//   grant_id  out  IDX_W   index currently owning the timer (valid when busy)
//   rejected  out  1       1-cycle pulse when a granted press fails confirmation
// BEHAVIOUR
// - Reset (rst=0, async): LED=0, busy=0, grant_id=0, rejected=0.
//   Also pending=0, rr_ptr=0, cnt=0, state=IDLE, and all sync flops=1 (released).
// - Input path per button: 2-flop synchronizer, then a 3rd flop holding the
//   previous value. A falling edge (prev=1, cur=0) sets pending[i] on that edge.
// - Presses of the currently granted index are ignored while busy.
//   A press of an already-pending index is absorbed (no count).
// - FSM:
//   IDLE    if |pending: pick the first set bit at or after rr_ptr, wrapping.
//           Then grant_id<=pick, clear pending[pick], cnt<=0, ->SETTLE.
//   SETTLE  cnt<=cnt+1. When cnt==DELAY_CNT-1: cnt<=0, ->CHECK.
//   CHECK   if synced button[grant_id]==0: LED[grant_id]<=1, ->PULSE.
//           Else rejected<=1 for one cycle, ->IDLE.
//           In both cases rr_ptr<=grant_id+1 (wraps N_BTN-1 -> 0).
//   PULSE   cnt<=cnt+1. When cnt==PULSE_CYC-1: LED<=0, cnt<=0, ->IDLE.
// - Latency with the arbiter idle: call E0 the first edge that samples button[i]=0.
//   LED[i] rises after edge E(DELAY_CNT+4) and stays high exactly PULSE_CYC cycles.
// - LED is registered and at most one bit is set at any time.
// - Simultaneous new pending set and grant clear of different bits are both applied.
//   A set and a clear of the same bit in one cycle cannot occur (granted index is ignored).
// - Counter never wraps. cnt compares are exact and DELAY_W bits wide.
// - Reset mid-operation aborts immediately. Outputs drop to reset values
//   asynchronously, and all pending presses are lost.
// STRUCTURE
//   Package btn_arb_pkg: state enum {IDLE,SETTLE,CHECK,PULSE} (2-bit), the
//   default DELAY_CNT/PULSE_CYC constants, and a function rr_pick(pending,ptr).
//   Sub-module btn_sync_edge (width-parameterised sync + falling-edge detect),
//   one instance of width N_BTN. FSM, counter and arbiter live in this module.
// TESTING  (bench overrides DELAY_CNT=8, PULSE_CYC=2, N_BTN=4)
//   1 Reset: rst=0 mid-SETTLE -> LED=0, busy=0, rejected=0 at once.
//     After release, no LED without a new press.
//   2 Single press: button[1] held low from E0 -> busy from E3, grant_id=1.
//     LED=4'b0010 rises after E12 for exactly 2 cycles, then busy=0.
//   3 Bounce: button[2] low 3 cycles then high -> rejected=1 for 1 cycle after E12.
//     LED stays 0 and rr_ptr=3.
//   4 Contention: buttons 0 and 3 fall on the same edge -> 0 confirmed first,
//     then 3. Both LEDs pulse, never overlapping; pending returns to 0.
//   5 Round-robin: rr_ptr=2 with pending=4'b1011 -> grant order 3, 0, 1.
//   6 Re-press of granted button 1 during SETTLE -> no extra LED pulse,
//     and pending[1] stays 0.

Source files
------------

// File: rtl/btn_arb_pkg.sv
// Shared types, default constants and the round-robin pick helper for
// button_debounce_arbiter.
package btn_arb_pkg;

    // Largest supported requester count and the index width that covers it.
    localparam int unsigned MAX_BTN   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    // Default timing: roughly 0.17 s hold-off at 100 MHz, single-cycle LED pulse.
    localparam int unsigned DEF_DELAY_CNT = 16777216;
    localparam int unsigned DEF_PULSE_CYC = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        PULSE  = 2'd3
    } state_t;

    // First set bit of pending at or after ptr, wrapping at n. Returns 0 when
    // pending is empty; callers only use the result when |pending.
    function automatic int unsigned rr_pick(
        input logic [MAX_BTN-1:0] pending,
        input int unsigned        ptr,
        input int unsigned        n
    );
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_BTN; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (k < n) && pending[idx[MAX_IDX_W-1:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Width-parameterised two-flop synchronizer plus a history flop for
// falling-edge detection on active-low inputs.
//   clk      : system clock
//   rst_n    : asynchronous reset, active-low; all flops reset to 1 (released)
//   i_async  : raw asynchronous inputs
//   o_sync   : synchronized level (registered)
//   o_fall_c : combinational falling-edge strobe (prev=1, cur=0)
module btn_sync_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_fall_c
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    // Synchronizer chain and one-cycle history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
            r_prev <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync   = r_sync;
    assign o_fall_c = r_prev & ~r_sync;

endmodule

// File: rtl/button_debounce_arbiter.sv
// Shares one debounce hold-off timer between N_BTN active-low buttons.
// Presses are latched as pending requests and granted round-robin; after the
// hold-off the granted button is re-sampled and a confirmed press produces a
// PULSE_CYC-long one-hot LED pulse on that lane.
//   clk      : system clock
//   rst      : asynchronous reset, active-low
//   button   : raw buttons, active-low, asynchronous
//   LED      : one-hot confirmed-press pulse, 0 when idle
//   busy     : high while the arbiter is not idle
//   grant_id : index owning the timer (valid when busy)
//   rejected : one-cycle pulse when a granted press fails confirmation
module button_debounce_arbiter
    import btn_arb_pkg::*;
#(
    parameter  int unsigned N_BTN     = 4,
    parameter  int unsigned DELAY_W   = 25,
    parameter  int unsigned DELAY_CNT = DEF_DELAY_CNT,
    parameter  int unsigned PULSE_CYC = DEF_PULSE_CYC,
    localparam int unsigned IDX_W     = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] LED,
    output logic             busy,
    output logic [IDX_W-1:0] grant_id,
    output logic             rejected
);

    logic [N_BTN-1:0]   w_sync;
    logic [N_BTN-1:0]   w_fall;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DELAY_W-1:0] r_cnt;
    logic [DELAY_W-1:0] w_cnt_nxt;
    logic [N_BTN-1:0]   r_pending;
    logic [N_BTN-1:0]   w_pending_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_rr_nxt;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   w_grant_nxt;
    logic [N_BTN-1:0]   r_led;
    logic [N_BTN-1:0]   w_led_nxt;
    logic               r_rej;
    logic               w_rej_nxt;
    logic               r_busy;
    logic               w_busy_nxt;

    logic [IDX_W-1:0]   w_pick;
    logic [N_BTN-1:0]   w_grant_mask;
    logic [N_BTN-1:0]   w_new_press;
    logic [IDX_W-1:0]   w_grant_inc;

    btn_sync_edge #(
        .W (N_BTN)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst),
        .i_async  (button),
        .o_sync   (w_sync),
        .o_fall_c (w_fall)
    );

    // Arbitration helpers.
    assign w_pick       = IDX_W'(rr_pick(MAX_BTN'(r_pending), 32'(r_rr_ptr), N_BTN));
    assign w_grant_mask = N_BTN'(1) << r_grant;
    assign w_grant_inc  = (r_grant == IDX_W'(N_BTN - 1)) ? '0 : r_grant + IDX_W'(1);

    // The granted lane is masked while busy, so a set and a clear of the
    // same pending bit never collide.
    assign w_new_press  = w_fall & ~(r_busy ? w_grant_mask : '0);

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_led     <= '0;
            r_rej     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_grant   <= w_grant_nxt;
            r_led     <= w_led_nxt;
            r_rej     <= w_rej_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending | w_new_press;
        w_rr_nxt      = r_rr_ptr;
        w_grant_nxt   = r_grant;
        w_led_nxt     = r_led;
        w_rej_nxt     = 1'b0;
        w_busy_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_grant_nxt           = w_pick;
                    w_pending_nxt[w_pick] = 1'b0;
                    w_cnt_nxt             = '0;
                    w_state_nxt           = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == DELAY_W'(DELAY_CNT - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = CHECK;
                end else begin
                    w_cnt_nxt = r_cnt + DELAY_W'(1);
                end
            end
            CHECK: begin
                w_rr_nxt = w_grant_inc;
                if (!w_sync[r_grant]) begin
                    w_led_nxt   = w_grant_mask;
                    w_state_nxt = PULSE;
                end else begin
                    w_rej_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            PULSE: begin
                if (r_cnt == DELAY_W'(PULSE_CYC - 1)) begin
                    w_led_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + DELAY_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign LED      = r_led;
    assign busy     = r_busy;
    assign grant_id = r_grant;
    assign rejected = r_rej;

endmodule
